// File: rtl/fx2_fifo_scheduler_if.sv
// Bundle of FX2 slave-FIFO bus signals plus the per-endpoint byte streams.
// master = scheduler side, slave = FX2 pins / user logic side.
interface fx2_fifo_scheduler_if;
    logic       fifo2_data_available;
    logic       fifo3_data_available;
    logic       fifo4_ready;
    logic       fifo5_ready;
    logic [7:0] fifo_datain;
    logic [7:0] fifo_dataout;
    logic [1:0] fifo_fifoadr;
    logic       fifo_rd;
    logic       fifo_wr;
    logic       fifo_pktend;
    logic       fifo_datain_oe;
    logic       fifo_dataout_oe;
    logic [7:0] rx2_data;
    logic [7:0] rx3_data;
    logic       rx2_valid;
    logic       rx3_valid;
    logic       rx2_ready;
    logic       rx3_ready;
    logic [7:0] tx4_data;
    logic [7:0] tx5_data;
    logic       tx4_valid;
    logic       tx5_valid;
    logic       tx4_pktend;
    logic       tx5_pktend;
    logic       tx4_ready;
    logic       tx5_ready;

    modport master (
        input  fifo2_data_available, fifo3_data_available, fifo4_ready, fifo5_ready,
        input  fifo_datain, rx2_ready, rx3_ready,
        input  tx4_data, tx5_data, tx4_valid, tx5_valid, tx4_pktend, tx5_pktend,
        output fifo_dataout, fifo_fifoadr, fifo_rd, fifo_wr, fifo_pktend,
        output fifo_datain_oe, fifo_dataout_oe,
        output rx2_data, rx3_data, rx2_valid, rx3_valid, tx4_ready, tx5_ready
    );

    modport slave (
        output fifo2_data_available, fifo3_data_available, fifo4_ready, fifo5_ready,
        output fifo_datain, rx2_ready, rx3_ready,
        output tx4_data, tx5_data, tx4_valid, tx5_valid, tx4_pktend, tx5_pktend,
        input  fifo_dataout, fifo_fifoadr, fifo_rd, fifo_wr, fifo_pktend,
        input  fifo_datain_oe, fifo_dataout_oe,
        input  rx2_data, rx3_data, rx2_valid, rx3_valid, tx4_ready, tx5_ready
    );
endinterface

// File: rtl/fx2_fifo_scheduler.sv
// Round-robin time-sharing of the FX2 slave-FIFO bus between two read endpoints
// (FIFO2/3, host->FPGA) and two write endpoints (FIFO4/5, FPGA->host), bounded bursts.
module fx2_fifo_scheduler #(
    parameter int BURST_MAX   = 64,
    parameter int ADDR_SETTLE = 1
) (
    input logic                  FIFO_CLK,
    input logic                  reset,
    fx2_fifo_scheduler_if.master bus
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(ADDR_SETTLE + 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_MAX - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(ADDR_SETTLE - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, READ, WRITE, PKTEND} state_t;

    state_t        state;
    logic [1:0]    adr;
    logic [1:0]    ch;
    logic [1:0]    rr_ptr;
    logic [1:0]    pick;
    logic [BW-1:0] burst_cnt;
    logic [SW-1:0] settle_cnt;
    logic          pend_pktend;
    logic [3:0]    elig;
    logic          rd;
    logic          wr;
    logic          tx_pktend_sel;
    logic [7:0]    rx2_data_p0;
    logic [7:0]    rx3_data_p0;
    logic          rx2_vld_p0;
    logic          rx3_vld_p0;

    // Channel index doubles as the FIFOADR code: 0=FIFO2 1=FIFO3 2=FIFO4 3=FIFO5.
    function automatic logic [1:0] rr_pick(input logic [3:0] e, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] res;
        res = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (e[idx]) res = idx;
        end
        return res;
    endfunction

    assign elig = {bus.tx5_valid & bus.fifo5_ready,
                   bus.tx4_valid & bus.fifo4_ready,
                   bus.fifo3_data_available & bus.rx3_ready,
                   bus.fifo2_data_available & bus.rx2_ready};
    assign pick = rr_pick(elig, rr_ptr);

    // Strobes are gated by the live flag, so a flag drop can never race a strobe.
    assign rd            = (state == READ)  && elig[ch];
    assign wr            = (state == WRITE) && elig[ch];
    assign tx_pktend_sel = ch[0] ? bus.tx5_pktend : bus.tx4_pktend;

    always_ff @(posedge FIFO_CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            adr         <= 2'd0;
            ch          <= 2'd0;
            rr_ptr      <= 2'd3;
            burst_cnt   <= '0;
            settle_cnt  <= '0;
            pend_pktend <= 1'b0;
            rx2_data_p0 <= 8'd0;
            rx3_data_p0 <= 8'd0;
            rx2_vld_p0  <= 1'b0;
            rx3_vld_p0  <= 1'b0;
        end else begin
            // Capture stage: byte on FD at a read edge appears on rxN one cycle later.
            rx2_vld_p0 <= rd && (ch == 2'd0);
            rx3_vld_p0 <= rd && (ch == 2'd1);
            if (rd && (ch == 2'd0)) rx2_data_p0 <= bus.fifo_datain;
            if (rd && (ch == 2'd1)) rx3_data_p0 <= bus.fifo_datain;

            case (state)
                IDLE: begin
                    if (|elig) begin
                        ch         <= pick;
                        burst_cnt  <= '0;
                        settle_cnt <= '0;
                        if (pick != adr) begin
                            adr   <= pick;
                            state <= SETTLE;
                        end else begin
                            state <= pick[1] ? WRITE : READ;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= ch[1] ? WRITE : READ;
                    else settle_cnt <= settle_cnt + 1'b1;
                end
                READ, WRITE: begin
                    if (!elig[ch]) begin
                        state  <= IDLE;
                        rr_ptr <= ch;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (wr && tx_pktend_sel) begin
                            pend_pktend <= 1'b1;
                            state       <= PKTEND;
                            rr_ptr      <= ch;
                        end else if (burst_cnt == BURST_LAST) begin
                            state  <= IDLE;
                            rr_ptr <= ch;
                        end
                    end
                end
                PKTEND: begin
                    pend_pktend <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_fifoadr    = adr;
    assign bus.fifo_rd         = rd;
    assign bus.fifo_wr         = wr;
    assign bus.fifo_pktend     = pend_pktend;
    assign bus.fifo_datain_oe  = (state == READ) || ((state == SETTLE) && !ch[1]);
    assign bus.fifo_dataout_oe = (state == WRITE) || (state == PKTEND) ||
                                 ((state == SETTLE) && ch[1]);
    assign bus.fifo_dataout    = ch[0] ? bus.tx5_data : bus.tx4_data;
    assign bus.tx4_ready       = wr && (ch == 2'd2);
    assign bus.tx5_ready       = wr && (ch == 2'd3);
    assign bus.rx2_data        = rx2_data_p0;
    assign bus.rx3_data        = rx3_data_p0;
    assign bus.rx2_valid       = rx2_vld_p0;
    assign bus.rx3_valid       = rx3_vld_p0;
endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
// Bench: FX2-side FIFO model and user-side streams driven from queues; a monitor
// scores every rx byte, every bus write and the bus protocol rules each cycle.
module tb_fx2_fifo_scheduler;
    localparam int BURST_MAX   = 4;
    localparam int ADDR_SETTLE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fx2_fifo_scheduler_if bus ();

    fx2_fifo_scheduler #(.BURST_MAX(BURST_MAX), .ADDR_SETTLE(ADDR_SETTLE)) dut (
        .FIFO_CLK (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fxq2[$], fxq3[$];
    logic [8:0] txq4[$], txq5[$];
    logic [7:0] exp_rx2[$], exp_rx3[$];
    logic [8:0] exp_h4[$], exp_h5[$];

    int p_avail, p_rxrdy, p_txv, p_frdy;
    bit f4_block;
    int xfer4;
    bit mon_en = 1'b0;

    int seg_adr[$], seg_len[$];
    int pk_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit rnd(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic add_rx(input int c, input logic [7:0] b);
        if (c == 2) begin fxq2.push_back(b); exp_rx2.push_back(b); end
        else        begin fxq3.push_back(b); exp_rx3.push_back(b); end
    endtask

    task automatic add_tx(input int c, input logic [8:0] w);
        if (c == 4) begin txq4.push_back(w); exp_h4.push_back(w); end
        else        begin txq5.push_back(w); exp_h5.push_back(w); end
    endtask

    task automatic idle_inputs();
        bus.fifo2_data_available = 1'b0; bus.fifo3_data_available = 1'b0;
        bus.fifo4_ready = 1'b0; bus.fifo5_ready = 1'b0;
        bus.fifo_datain = 8'd0;
        bus.rx2_ready = 1'b0; bus.rx3_ready = 1'b0;
        bus.tx4_data = 8'd0; bus.tx5_data = 8'd0;
        bus.tx4_valid = 1'b0; bus.tx5_valid = 1'b0;
        bus.tx4_pktend = 1'b0; bus.tx5_pktend = 1'b0;
    endtask

    task automatic reset_dut();
        mon_en = 1'b0;
        rst = 1'b1;
        fxq2.delete(); fxq3.delete(); txq4.delete(); txq5.delete();
        exp_rx2.delete(); exp_rx3.delete(); exp_h4.delete(); exp_h5.delete();
        p_avail = 100; p_rxrdy = 100; p_txv = 100; p_frdy = 100;
        f4_block = 1'b0; xfer4 = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    // One bus cycle: FX2 FIFOs and user streams present data, then commit what the edge will take.
    task automatic drive_cycle();
        @(negedge clk);
        bus.fifo2_data_available = (fxq2.size() > 0) && rnd(p_avail);
        bus.fifo3_data_available = (fxq3.size() > 0) && rnd(p_avail);
        bus.rx2_ready   = rnd(p_rxrdy);
        bus.rx3_ready   = rnd(p_rxrdy);
        bus.fifo4_ready = rnd(p_frdy) && !f4_block;
        bus.fifo5_ready = rnd(p_frdy);
        bus.tx4_valid   = (txq4.size() > 0) && rnd(p_txv);
        bus.tx5_valid   = (txq5.size() > 0) && rnd(p_txv);
        {bus.tx4_pktend, bus.tx4_data} = (txq4.size() > 0) ? txq4[0] : {1'b0, 8'($urandom)};
        {bus.tx5_pktend, bus.tx5_data} = (txq5.size() > 0) ? txq5[0] : {1'b0, 8'($urandom)};
        if (bus.fifo_fifoadr == 2'd0 && fxq2.size() > 0)      bus.fifo_datain = fxq2[0];
        else if (bus.fifo_fifoadr == 2'd1 && fxq3.size() > 0) bus.fifo_datain = fxq3[0];
        else                                                  bus.fifo_datain = 8'($urandom);
        #1;
        if (bus.fifo_rd && bus.fifo_fifoadr == 2'd0 && fxq2.size() > 0) void'(fxq2.pop_front());
        if (bus.fifo_rd && bus.fifo_fifoadr == 2'd1 && fxq3.size() > 0) void'(fxq3.pop_front());
        if (bus.tx4_valid && bus.tx4_ready && txq4.size() > 0) begin
            void'(txq4.pop_front());
            xfer4++;
        end
        if (bus.tx5_valid && bus.tx5_ready && txq5.size() > 0) void'(txq5.pop_front());
    endtask

    task automatic chk_seg(input int k, input int a, input int l);
        if (seg_adr.size() > k) begin
            chk($sformatf("grant %0d fifoadr", k), seg_adr[k], a);
            chk($sformatf("grant %0d length", k), seg_len[k], l);
        end else begin
            chk($sformatf("grant %0d present", k), seg_adr.size(), k + 1);
        end
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, " rx2 bytes outstanding"}, exp_rx2.size(), 0);
        chk({tag, " rx3 bytes outstanding"}, exp_rx3.size(), 0);
        chk({tag, " fifo4 bytes outstanding"}, exp_h4.size(), 0);
        chk({tag, " fifo5 bytes outstanding"}, exp_h5.size(), 0);
    endtask

    // Monitor state
    logic [1:0] m_prev_adr;
    int         m_since, m_cur_adr, m_cur_len;
    bit         m_prev_din, m_prev_dout, m_prev_rd2, m_prev_rd3, m_need_pk;
    logic [1:0] m_pk_adr;

    initial begin : monitor
        bit         ok, strobe, gate, nxt_pk;
        logic [8:0] e9;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                m_prev_adr = bus.fifo_fifoadr; m_since = ADDR_SETTLE;
                m_cur_adr = 0; m_cur_len = 0;
                m_prev_din = 1'b0; m_prev_dout = 1'b0;
                m_prev_rd2 = 1'b0; m_prev_rd3 = 1'b0; m_need_pk = 1'b0; m_pk_adr = 2'd0;
                seg_adr.delete(); seg_len.delete(); pk_cnt = 0;
            end else begin
                strobe = bus.fifo_rd || bus.fifo_wr;
                if (bus.fifo_fifoadr != m_prev_adr) m_since = 0;
                else if (m_since < 1000) m_since++;

                ok = !(bus.fifo_datain_oe && bus.fifo_dataout_oe)
                  && !(bus.fifo_rd && bus.fifo_wr)
                  && (!bus.fifo_rd || (bus.fifo_datain_oe && !bus.fifo_fifoadr[1]))
                  && (!bus.fifo_wr || (bus.fifo_dataout_oe && bus.fifo_fifoadr[1]))
                  && !(bus.fifo_datain_oe && m_prev_dout)
                  && !(bus.fifo_dataout_oe && m_prev_din)
                  && (bus.tx4_ready == (bus.fifo_wr && bus.fifo_fifoadr == 2'd2))
                  && (bus.tx5_ready == (bus.fifo_wr && bus.fifo_fifoadr == 2'd3));
                chk("bus protocol", int'(ok), 1);

                if (strobe) begin
                    case (bus.fifo_fifoadr)
                        2'd0:    gate = bus.fifo2_data_available && bus.rx2_ready;
                        2'd1:    gate = bus.fifo3_data_available && bus.rx3_ready;
                        2'd2:    gate = bus.fifo4_ready && bus.tx4_valid;
                        default: gate = bus.fifo5_ready && bus.tx5_valid;
                    endcase
                    chk("strobe gated by eligibility", int'(gate), 1);
                    chk("address settled before strobe", int'(m_since >= ADDR_SETTLE), 1);
                    if (m_cur_len > 0 && int'(bus.fifo_fifoadr) == m_cur_adr) begin
                        m_cur_len++;
                    end else begin
                        if (m_cur_len > 0) begin
                            seg_adr.push_back(m_cur_adr); seg_len.push_back(m_cur_len);
                        end
                        m_cur_adr = int'(bus.fifo_fifoadr);
                        m_cur_len = 1;
                    end
                    chk("burst length bound", int'(m_cur_len <= BURST_MAX), 1);
                end else if (m_cur_len > 0) begin
                    seg_adr.push_back(m_cur_adr); seg_len.push_back(m_cur_len);
                    m_cur_len = 0;
                end

                if (bus.rx2_valid || m_prev_rd2) chk("rx2 valid one cycle after rd", int'(bus.rx2_valid), int'(m_prev_rd2));
                if (bus.rx3_valid || m_prev_rd3) chk("rx3 valid one cycle after rd", int'(bus.rx3_valid), int'(m_prev_rd3));
                if (bus.rx2_valid) begin
                    if (exp_rx2.size() > 0) chk("rx2 data", int'(bus.rx2_data), int'(exp_rx2.pop_front()));
                    else chk("rx2 unexpected byte", exp_rx2.size(), 1);
                end
                if (bus.rx3_valid) begin
                    if (exp_rx3.size() > 0) chk("rx3 data", int'(bus.rx3_data), int'(exp_rx3.pop_front()));
                    else chk("rx3 unexpected byte", exp_rx3.size(), 1);
                end

                if (m_need_pk || bus.fifo_pktend) begin
                    chk("pktend after last byte",
                        int'({bus.fifo_pktend, bus.fifo_wr, bus.fifo_dataout_oe, bus.fifo_fifoadr == m_pk_adr}),
                        int'({m_need_pk, 1'b0, 1'b1, 1'b1}));
                    if (bus.fifo_pktend) pk_cnt++;
                end

                nxt_pk = 1'b0;
                if (bus.fifo_wr) begin
                    if (bus.fifo_fifoadr == 2'd2 && exp_h4.size() > 0) begin
                        e9 = exp_h4.pop_front();
                        chk("fifo4 byte on bus", int'(bus.fifo_dataout), int'(e9[7:0]));
                        nxt_pk = e9[8];
                    end else if (bus.fifo_fifoadr == 2'd3 && exp_h5.size() > 0) begin
                        e9 = exp_h5.pop_front();
                        chk("fifo5 byte on bus", int'(bus.fifo_dataout), int'(e9[7:0]));
                        nxt_pk = e9[8];
                    end else begin
                        chk("unexpected bus write", int'(bus.fifo_fifoadr), -1);
                    end
                end
                m_need_pk   = nxt_pk;
                m_pk_adr    = bus.fifo_fifoadr;
                m_prev_rd2  = bus.fifo_rd && bus.fifo_fifoadr == 2'd0;
                m_prev_rd3  = bus.fifo_rd && bus.fifo_fifoadr == 2'd1;
                m_prev_din  = bus.fifo_datain_oe;
                m_prev_dout = bus.fifo_dataout_oe;
                m_prev_adr  = bus.fifo_fifoadr;
            end
        end
    end

    initial begin : stimulus
        bit found;
        int blk;
        rst = 1'b1;
        idle_inputs();
        bus.tx4_valid = 1'b1; bus.fifo4_ready = 1'b1;
        bus.fifo2_data_available = 1'b1; bus.rx2_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset fifoadr", int'(bus.fifo_fifoadr), 0);
        chk("reset strobes rd/wr/pktend", int'({bus.fifo_rd, bus.fifo_wr, bus.fifo_pktend}), 0);
        chk("reset output enables", int'({bus.fifo_datain_oe, bus.fifo_dataout_oe}), 0);
        chk("reset rx valid/data", int'({bus.rx2_valid, bus.rx3_valid, bus.rx2_data, bus.rx3_data}), 0);
        chk("reset tx ready", int'({bus.tx4_ready, bus.tx5_ready}), 0);

        // Read three bytes from FIFO2, then flag goes low.
        reset_dut();
        add_rx(2, 8'h11); add_rx(2, 8'h22); add_rx(2, 8'h33);
        repeat (12) drive_cycle();
        chk_seg(0, 0, 3);
        chk("fifo2 burst count", seg_adr.size(), 1);
        chk_drained("fifo2 read");

        // All four endpoints permanently eligible: 2,3,4,5,2 with full bursts.
        reset_dut();
        for (int i = 0; i < 24; i++) begin
            add_rx(2, 8'($urandom)); add_rx(3, 8'($urandom));
            add_tx(4, {1'b0, 8'($urandom)}); add_tx(5, {1'b0, 8'($urandom)});
        end
        repeat (60) drive_cycle();
        chk_seg(0, 0, BURST_MAX);
        chk_seg(1, 1, BURST_MAX);
        chk_seg(2, 2, BURST_MAX);
        chk_seg(3, 3, BURST_MAX);
        chk_seg(4, 0, BURST_MAX);

        // Short IN packet on FIFO4 committed with pktend.
        reset_dut();
        add_tx(4, {1'b0, 8'hA1}); add_tx(4, {1'b0, 8'hA2}); add_tx(4, {1'b1, 8'hA3});
        repeat (20) drive_cycle();
        chk_seg(0, 2, 3);
        chk("pktend burst count", seg_adr.size(), 1);
        chk("pktend pulses", pk_cnt, 1);
        chk_drained("pktend");

        // FIFO4 goes full after two bytes, then recovers.
        reset_dut();
        for (int i = 0; i < 6; i++) add_tx(4, {1'b0, 8'(8'hC0 + i)});
        blk = 0;
        for (int i = 0; i < 40; i++) begin
            f4_block = (xfer4 == 2) && (blk < 4);
            if (f4_block) blk++;
            drive_cycle();
        end
        chk_seg(0, 2, 2);
        chk_seg(1, 2, 4);
        chk_drained("fifo4 full");

        // Direction change: read FIFO2 then write FIFO4.
        reset_dut();
        add_rx(2, 8'h5A); add_rx(2, 8'hA5);
        add_tx(4, {1'b0, 8'h3C}); add_tx(4, {1'b0, 8'hC3});
        repeat (20) drive_cycle();
        chk_seg(0, 0, 2);
        chk_seg(1, 2, 2);
        chk_drained("turnaround");

        // Asynchronous reset in the middle of a FIFO4 burst.
        reset_dut();
        for (int i = 0; i < 20; i++) add_tx(4, {1'b0, 8'($urandom)});
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive_cycle();
            if (bus.fifo_wr && bus.fifo_fifoadr == 2'd2) found = 1'b1;
        end
        chk("write burst reached before reset", int'(found), 1);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async reset drops wr", int'(bus.fifo_wr), 0);
        chk("async reset drops dataout_oe", int'(bus.fifo_dataout_oe), 0);
        chk("async reset drops tx4_ready", int'(bus.tx4_ready), 0);
        chk("async reset fifoadr", int'(bus.fifo_fifoadr), 0);

        // Randomised traffic on all four endpoints, then drain.
        reset_dut();
        for (int i = 0; i < 150; i++) begin
            add_rx(2, 8'($urandom)); add_rx(3, 8'($urandom));
            add_tx(4, {($urandom_range(7) == 0), 8'($urandom)});
            add_tx(5, {($urandom_range(7) == 0), 8'($urandom)});
        end
        p_avail = 60; p_rxrdy = 70; p_txv = 70; p_frdy = 70;
        repeat (4000) drive_cycle();
        p_avail = 100; p_rxrdy = 100; p_txv = 100; p_frdy = 100;
        repeat (1500) drive_cycle();
        chk_drained("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
